// File: rtl/picnic_uart_pkg.sv
// Shared UART framing constants, framer state encoding and baud divisor helper.
package picnic_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit.
module uart_byte_tx
    import picnic_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      i_load,
    input  logic [UART_DATA_BITS-1:0] i_data,
    output logic                      o_txd,
    output logic                      o_tx_busy,
    output logic                      o_tx_done
);

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int              FW        = UART_DATA_BITS + 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]      BIT_LAST  = 4'(UART_DATA_BITS + 1);

    logic [FW-1:0] r_frame;
    logic [3:0]    r_bit_cnt;
    logic [BW-1:0] r_baud_cnt;
    logic          r_txd;
    logic          r_busy;
    logic          r_done;

    // Bit/baud sequencing; done is raised during the final stop-bit cycle so the
    // framer can react exactly at stop-bit end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_txd      <= UART_STOP_BIT;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= {BW{1'b0}};
            r_frame    <= {FW{1'b1}};
        end else begin
            r_done <= r_busy && (r_bit_cnt == BIT_LAST) && (r_baud_cnt == BAUD_PRE);
            if (!r_busy) begin
                if (i_load) begin
                    r_busy     <= 1'b1;
                    r_txd      <= UART_START_BIT;
                    r_frame    <= {UART_STOP_BIT, i_data};
                    r_bit_cnt  <= 4'd0;
                    r_baud_cnt <= {BW{1'b0}};
                end
            end else if (r_baud_cnt == BAUD_LAST) begin
                r_baud_cnt <= {BW{1'b0}};
                if (r_bit_cnt == BIT_LAST) begin
                    r_busy <= 1'b0;
                    r_txd  <= UART_STOP_BIT;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_txd     <= r_frame[0];
                    r_frame   <= {UART_STOP_BIT, r_frame[FW-1:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + BW'(1);
            end
        end
    end

    assign o_txd     = r_txd;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule

// File: rtl/ram_uart_tx_framer.sv
// Streams NUM_BYTES bytes from a byte RAM out as UART 8N1 frames.
// Optional trailing checksum byte: define RAM_UART_TX_CSUM_EN.
module ram_uart_tx_framer
    import picnic_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int AW        = 15,
    parameter int BASE_ADDR = 0,
    parameter int NUM_BYTES = 32
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          i_start,
    input  logic [7:0]    i_ram_dout,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_uart_txd,
    output logic          o_busy,
    output logic          o_done
);

    localparam int            CPB      = clks_per_bit(CLK_FREQ, BAUD);
    localparam int            IW       = $clog2(NUM_BYTES + 1);
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [IW-1:0] LAST_CNT = IW'(NUM_BYTES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_index;
    logic [IW-1:0] w_index_inc;
    logic [AW-1:0] r_ram_addr;
    logic          r_busy;
    logic          r_done;
    logic          w_tx_load;
    logic [7:0]    w_tx_data;
    logic          w_txd;
    logic          w_tx_busy;
    logic          w_tx_done;
`ifdef RAM_UART_TX_CSUM_EN
    logic [7:0]    r_csum;
    logic [1:0]    r_gap;
`endif

    assign w_index_inc = r_index + IW'(1);

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and byte launch strobe
    always_comb begin
        w_state_nxt = r_state;
        w_tx_load   = 1'b0;
        w_tx_data   = i_ram_dout;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_ADDR;
                else         w_state_nxt = S_IDLE;
            end
            S_ADDR: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (!w_tx_busy) begin
                    w_tx_load   = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_SEND: begin
                if (!w_tx_done)                w_state_nxt = S_SEND;
                else if (w_index_inc < LAST_CNT) w_state_nxt = S_ADDR;
`ifdef RAM_UART_TX_CSUM_EN
                else                           w_state_nxt = S_CSUM;
`else
                else                           w_state_nxt = S_DONE;
`endif
            end
`ifdef RAM_UART_TX_CSUM_EN
            S_CSUM: begin
                w_tx_data = 8'd0 - r_csum;
                if (r_gap == 2'd2)                    w_tx_load   = 1'b1;
                else if (r_gap == 2'd3 && w_tx_done)  w_state_nxt = S_DONE;
                else                                  w_state_nxt = S_CSUM;
            end
`endif
            S_DONE: begin
                if (!i_start) w_state_nxt = S_IDLE;
                else          w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath: address, index, handshake flags and checksum
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ram_addr <= BASE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_index    <= {IW{1'b0}};
`ifdef RAM_UART_TX_CSUM_EN
            r_csum     <= 8'd0;
            r_gap      <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy  <= 1'b1;
                        r_index <= {IW{1'b0}};
`ifdef RAM_UART_TX_CSUM_EN
                        r_csum  <= 8'd0;
`endif
                    end
                end
                S_ADDR: r_ram_addr <= BASE + AW'(r_index);
`ifdef RAM_UART_TX_CSUM_EN
                S_LOAD: r_csum <= r_csum + i_ram_dout;
`endif
                S_SEND: begin
                    if (w_tx_done) begin
                        r_index <= w_index_inc;
`ifdef RAM_UART_TX_CSUM_EN
                        r_gap   <= 2'd0;
`endif
                        if (w_state_nxt == S_DONE) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end
`ifdef RAM_UART_TX_CSUM_EN
                S_CSUM: begin
                    if (r_gap != 2'd3) r_gap <= r_gap + 2'd1;
                    if (w_state_nxt == S_DONE) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (!i_start) r_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_load    (w_tx_load),
        .i_data    (w_tx_data),
        .o_txd     (w_txd),
        .o_tx_busy (w_tx_busy),
        .o_tx_done (w_tx_done)
    );

    assign o_ram_addr = r_ram_addr;
    assign o_uart_txd = w_txd;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_ram_uart_tx_framer.sv
// Directed bench for ram_uart_tx_framer: line decode, bit timing, handshake, reset and address wrap.
module tb_ram_uart_tx_framer;

    localparam int AW        = 15;
    localparam int NB        = 4;
    localparam int FRAME_CYC = 10 * 10 + 3;
`ifdef RAM_UART_TX_CSUM_EN
    localparam int NB_LINE = NB + 1;
`else
    localparam int NB_LINE = NB;
`endif

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          start_m   = 1'b0;
    logic          start_w   = 1'b0;
    logic [7:0]    dout_m;
    logic [7:0]    dout_w;
    logic [AW-1:0] addr_m;
    logic [AW-1:0] addr_w;
    logic          txd_m, txd_w, busy_m, busy_w, done_m, done_w;
    logic [7:0]    mem_m [0:32767];
    logic [7:0]    mem_w [0:32767];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk) begin
        dout_m <= mem_m[addr_m];
        dout_w <= mem_w[addr_w];
    end

    ram_uart_tx_framer #(
        .CLK_FREQ (1000), .BAUD (100), .AW (AW), .BASE_ADDR ('h10), .NUM_BYTES (NB)
    ) u_dut (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .i_start (start_m), .i_ram_dout (dout_m),
        .o_ram_addr (addr_m), .o_uart_txd (txd_m), .o_busy (busy_m), .o_done (done_m)
    );

    ram_uart_tx_framer #(
        .CLK_FREQ (1000), .BAUD (100), .AW (AW), .BASE_ADDR ('h7FFE), .NUM_BYTES (NB)
    ) u_dut_wrap (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .i_start (start_w), .i_ram_dout (dout_w),
        .o_ram_addr (addr_w), .o_uart_txd (txd_w), .o_busy (busy_w), .o_done (done_w)
    );

    // Line receiver: samples mid-bit on the falling clock edge, stores {stop, data}
    logic       mon_sel = 1'b0;
    logic       mon_txd;
    logic [8:0] rx_bytes[$];
    int         rx_fall[$];
    logic       rx_act = 1'b0;
    logic       rx_cap = 1'b0;
    int         rx_n   = 0;
    logic [8:0] rx_sh;
    logic       rx_samp [0:99];

    assign mon_txd = mon_sel ? txd_w : txd_m;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_act = 1'b0;
        end else begin
            if (!rx_act && mon_txd == 1'b0) begin
                rx_act = 1'b1;
                rx_n   = 0;
                rx_sh  = 9'd0;
                rx_cap = (rx_bytes.size() == 0);
                rx_fall.push_back(cyc);
            end else if (rx_act) begin
                rx_n++;
            end
            if (rx_act) begin
                if (rx_cap) rx_samp[rx_n] = mon_txd;
                if (rx_n >= 15 && rx_n % 10 == 5) rx_sh = {mon_txd, rx_sh[8:1]};
                if (rx_n == 95) rx_bytes.push_back(rx_sh);
                if (rx_n == 99) rx_act = 1'b0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input logic sel, output int t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            @(negedge sys_clk);
            if ((sel ? done_w : done_m) == 1'b1) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_fall.delete();
    endtask

    task automatic check_line(input string tag, input int t0,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] e [0:4];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4;
        check_val($sformatf("%s_nbytes", tag), rx_bytes.size(), NB_LINE);
        for (int k = 0; k < NB_LINE; k++) begin
            if (k < rx_bytes.size())
                check_val($sformatf("%s_byte%0d", tag, k), {23'd0, rx_bytes[k]}, {23'd0, 1'b1, e[k]});
            if (k < rx_fall.size())
                check_val($sformatf("%s_fall%0d", tag, k), rx_fall[k], t0 + 3 + k * FRAME_CYC);
        end
    endtask

    initial begin
        int         t0;
        int         td;
        logic [9:0] exp_bits;
        logic [9:0] got_bits;

        for (int a = 0; a < 32768; a++) begin
            mem_m[a] = 8'h00;
            mem_w[a] = 8'h00;
        end
        mem_m['h10] = 8'hA5; mem_m['h11] = 8'h00; mem_m['h12] = 8'hFF; mem_m['h13] = 8'h3C;
        mem_w['h7FFE] = 8'h11; mem_w['h7FFF] = 8'h22; mem_w['h0000] = 8'h33; mem_w['h0001] = 8'h44;

        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_val("rst_txd",  txd_m,  1);
        check_val("rst_busy", busy_m, 0);
        check_val("rst_done", done_m, 0);
        check_val("rst_addr", addr_m, 'h10);
        check_val("rst_addr_wrap", addr_w, 'h7FFE);
        sys_rst_n = 1'b1;

        // Full block, bit timing, drop start on the done cycle
        clear_rx();
        @(negedge sys_clk);
        start_m = 1'b1;
        t0 = cyc + 1;
        @(negedge sys_clk);
        check_val("t1_busy_high", busy_m, 1);
        wait_done(1'b0, td);
        check_val("t1_done_cyc", td, t0 + NB_LINE * FRAME_CYC);
        check_val("t1_busy_low", busy_m, 0);
        check_val("t1_txd_idle", txd_m, 1);
        start_m = 1'b0;
        @(negedge sys_clk);
        check_val("t3_done_one_cycle", done_m, 0);
        repeat (150) @(negedge sys_clk);
        check_val("t3_no_restart", rx_fall.size(), NB_LINE);
        check_val("t3_idle_busy", busy_m, 0);
        check_line("t1", t0, 8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h20);

        exp_bits = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) got_bits[j] = rx_samp[i * 10 + j];
            check_val($sformatf("t2_bit%0d", i), got_bits, exp_bits[i] ? 10'h3FF : 10'h000);
        end

        // Reset in the middle of bit 2 of the second byte (0x00)
        clear_rx();
        @(negedge sys_clk);
        start_m = 1'b1;
        t0 = cyc + 1;
        repeat (132) @(negedge sys_clk);
        check_val("t4_pre_txd", txd_m, 0);
        check_val("t4_pre_busy", busy_m, 1);
        sys_rst_n = 1'b0;
        start_m   = 1'b0;
        #1;
        check_val("t4_rst_txd",  txd_m,  1);
        check_val("t4_rst_busy", busy_m, 0);
        check_val("t4_rst_done", done_m, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_rx();
        @(negedge sys_clk);
        start_m = 1'b1;
        t0 = cyc + 1;
        wait_done(1'b0, td);
        start_m = 1'b0;
        check_line("t4", t0, 8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h20);
        @(negedge sys_clk);

        // Address wrap; start held high through DONE must not retrigger
        mon_sel = 1'b1;
        clear_rx();
        @(negedge sys_clk);
        start_w = 1'b1;
        t0 = cyc + 1;
        wait_done(1'b1, td);
        check_val("t5_done_cyc", td, t0 + NB_LINE * FRAME_CYC);
        repeat (20) @(negedge sys_clk);
        check_val("t5_done_held", done_w, 1);
        check_val("t5_busy_low", busy_w, 0);
        check_val("t5_no_retrigger", rx_fall.size(), NB_LINE);
        check_val("t5_addr_last", addr_w, 'h0001);
        start_w = 1'b0;
        @(negedge sys_clk);
        check_val("t5_done_clear", done_w, 0);
        check_line("t5", t0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56);
        mon_sel = 1'b0;

        // Checksum payload; start dropped mid-transfer
        mem_m['h10] = 8'h01; mem_m['h11] = 8'h02; mem_m['h12] = 8'h03; mem_m['h13] = 8'h04;
        clear_rx();
        @(negedge sys_clk);
        start_m = 1'b1;
        t0 = cyc + 1;
        repeat (50) @(negedge sys_clk);
        start_m = 1'b0;
        wait_done(1'b0, td);
        check_val("t6_done_cyc", td, t0 + NB_LINE * FRAME_CYC);
        @(negedge sys_clk);
        check_val("t6_done_one_cycle", done_m, 0);
        check_val("t6_addr_last", addr_m, 'h13);
        repeat (150) @(negedge sys_clk);
        check_line("t6", t0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
